complete_arbiter: RTL and testbench

//   Shares the single completion path (regfile write port + rename-table

---
 rtl/complete_arbiter_pkg.sv | 31 +++
 rtl/complete_arbiter_rr.sv | 36 +++
 rtl/complete_arbiter.sv | 83 ++++++++
 tb/tb_complete_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/complete_arbiter_pkg.sv
// Shared types for the completion arbiter: the packed completion message
// carried from the writeback pipes onto the CompleteNotif broadcast.
package complete_arbiter_pkg;

  localparam int unsigned SEQ_BITS      = 5;
  localparam int unsigned NUM_PHYS_REGS = 36;
  localparam int unsigned PREG_BITS     = $clog2(NUM_PHYS_REGS);
  localparam int unsigned WADDR_BITS    = 5;
  localparam int unsigned WDATA_BITS    = 32;

  typedef struct packed {
    logic [SEQ_BITS-1:0]   seq_num;
    logic [WADDR_BITS-1:0] waddr;
    logic [PREG_BITS-1:0]  preg;
    logic [WDATA_BITS-1:0] wdata;
    logic                  wen;
  } complete_msg_t;

  localparam int unsigned MSG_BITS = $bits(complete_msg_t);

  // A single pipe still needs a 1-bit pointer field.
  function automatic int unsigned ptr_bits(int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

  // Trace column: ASCII digit of the granted pipe, or a space when idle.
  function automatic logic [7:0] trace_char(logic granted, logic [7:0] idx);
    return granted ? (8'h30 + idx) : 8'h20;
  endfunction

endpackage

// File: rtl/complete_arbiter_rr.sv
// Combinational rotating-priority arbiter: one-hot grant to the first
// requester found scanning upward from i_ptr, modulo the pipe count.
module complete_arbiter_rr
  import complete_arbiter_pkg::*;
#(
  parameter int unsigned p_num_pipes = 2,
  parameter int unsigned p_ptr_bits  = ptr_bits(p_num_pipes)
) (
  input  logic [p_num_pipes-1:0] i_req,
  input  logic [p_ptr_bits-1:0]  i_ptr,
  output logic [p_num_pipes-1:0] o_grant,
  output logic [p_ptr_bits-1:0]  o_winner,
  output logic                   o_any
);

  logic [31:0] w_idx;
  logic        w_hit;

  // Scan offsets 0..N-1 from the pointer; the first hit blocks all later ones.
  always_comb begin
    o_grant  = '0;
    o_winner = '0;
    o_any    = 1'b0;
    w_idx    = 32'd0;
    w_hit    = 1'b0;
    for (int unsigned k = 0; k < p_num_pipes; k++) begin
      w_idx = 32'(i_ptr) + 32'(k);
      w_idx = (w_idx >= 32'(p_num_pipes)) ? (w_idx - 32'(p_num_pipes)) : w_idx;
      w_hit = i_req[w_idx] & ~o_any;
      o_grant[w_idx] = w_hit;
      o_winner = w_hit ? p_ptr_bits'(w_idx) : o_winner;
      o_any    = o_any | w_hit;
    end
  end

endmodule

// File: rtl/complete_arbiter.sv
// Round-robin share of the single completion path among the writeback pipes;
// the granted message is registered onto the completion broadcast.
module complete_arbiter
  import complete_arbiter_pkg::*;
#(
  parameter  int unsigned p_num_pipes     = 2,
  parameter  int unsigned p_num_phys_regs = NUM_PHYS_REGS,
  parameter  int unsigned p_seq_num_bits  = SEQ_BITS,
  localparam int unsigned P               = $clog2(p_num_phys_regs),
  localparam int unsigned PW              = ptr_bits(p_num_pipes)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic          [p_num_pipes-1:0] req_val,
  output logic          [p_num_pipes-1:0] req_rdy,
  input  complete_msg_t [p_num_pipes-1:0] req_msg,
  output logic                          complete_val,
  output logic [p_seq_num_bits-1:0]     complete_seq,
  output logic [4:0]                    complete_waddr,
  output logic [P-1:0]                  complete_preg,
  output logic [31:0]                   complete_wdata,
  output logic                          complete_wen,
  output logic [PW-1:0]                 grant_ptr
);

  logic [p_num_pipes-1:0] w_grant;
  logic [PW-1:0]          w_winner;
  logic                   w_any;
  logic [PW-1:0]          w_ptr_nxt;
  complete_msg_t          w_msg_nxt;
  logic [PW-1:0]          r_ptr;
  logic                   r_val;
  complete_msg_t          r_msg;

  complete_arbiter_rr #(
    .p_num_pipes (p_num_pipes),
    .p_ptr_bits  (PW)
  ) u_rr (
    .i_req    (req_val),
    .i_ptr    (r_ptr),
    .o_grant  (w_grant),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  // Nothing is consumed while reset clears the broadcast register.
  assign req_rdy = rst ? '0 : (req_val & w_grant);

  // Pointer moves just past the winner; an idle cycle loads a cleared message.
  always_comb begin
    w_ptr_nxt = r_ptr;
    w_msg_nxt = '0;
    if (w_any) begin
      w_ptr_nxt = (32'(w_winner) == (p_num_pipes - 32'd1)) ? '0 : (w_winner + PW'(1));
      w_msg_nxt = req_msg[w_winner];
    end else begin
      w_ptr_nxt = r_ptr;
      w_msg_nxt = '0;
    end
  end

  // Broadcast register loads every cycle; there is no back-pressure downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
      r_val <= 1'b0;
      r_msg <= '0;
    end else begin
      r_ptr <= w_ptr_nxt;
      r_val <= w_any;
      r_msg <= w_msg_nxt;
    end
  end

  assign complete_val   = r_val;
  assign complete_seq   = r_msg.seq_num;
  assign complete_waddr = r_msg.waddr;
  assign complete_preg  = r_msg.preg;
  assign complete_wdata = r_msg.wdata;
  assign complete_wen   = r_msg.wen;
  assign grant_ptr      = r_ptr;

endmodule

// File: tb/tb_complete_arbiter.sv
// Directed plus randomized bench for complete_arbiter with N=2 and N=3
// instances, checked against a scan-from-pointer reference model.
module tb_complete_arbiter;
  import complete_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0] val2, rdy2;
  complete_msg_t [1:0] msg2;
  logic o2_val, o2_wen;
  logic [4:0] o2_seq, o2_waddr;
  logic [5:0] o2_preg;
  logic [31:0] o2_wdata;
  logic [0:0] o2_ptr;

  logic [2:0] val3, rdy3;
  complete_msg_t [2:0] msg3;
  logic o3_val, o3_wen;
  logic [4:0] o3_seq, o3_waddr;
  logic [5:0] o3_preg;
  logic [31:0] o3_wdata;
  logic [1:0] o3_ptr;

  complete_arbiter #(.p_num_pipes(2)) dut2 (
    .clk(clk), .rst(rst), .req_val(val2), .req_rdy(rdy2), .req_msg(msg2),
    .complete_val(o2_val), .complete_seq(o2_seq), .complete_waddr(o2_waddr),
    .complete_preg(o2_preg), .complete_wdata(o2_wdata), .complete_wen(o2_wen),
    .grant_ptr(o2_ptr));

  complete_arbiter #(.p_num_pipes(3)) dut3 (
    .clk(clk), .rst(rst), .req_val(val3), .req_rdy(rdy3), .req_msg(msg3),
    .complete_val(o3_val), .complete_seq(o3_seq), .complete_waddr(o3_waddr),
    .complete_preg(o3_preg), .complete_wdata(o3_wdata), .complete_wen(o3_wen),
    .grant_ptr(o3_ptr));

  int n_checks = 0;
  int n_err = 0;

  // Reference model: index 0 is the N=2 instance, index 1 the N=3 instance.
  int            m_ptr [2] = '{0, 0};
  bit            m_val [2] = '{1'b0, 1'b0};
  complete_msg_t m_msg [2];
  int            last_w [2] = '{-1, -1};
  bit            last_rst = 1'b1;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_win(int n, int ptr, logic [2:0] v);
    for (int k = 0; k < n; k++) begin
      if (v[(ptr + k) % n] === 1'b1) return (ptr + k) % n;
    end
    return -1;
  endfunction

  task automatic check_dut(int d, int n, logic [2:0] v, logic [2:0] rdy, logic cv, logic cw,
                           logic [1:0] cp, logic [4:0] cs, logic [4:0] ca, logic [5:0] cpr,
                           logic [31:0] cd);
    int w;
    logic [2:0] e;
    w = model_win(n, m_ptr[d], v);
    e = (rst || w < 0) ? 3'b000 : 3'(1 << w);
    chk($sformatf("rdy_n%0d", n), 64'(rdy), 64'(e));
    chk($sformatf("val_n%0d", n), 64'(cv), 64'(m_val[d]));
    chk($sformatf("wen_n%0d", n), 64'(cw), 64'(m_msg[d].wen));
    chk($sformatf("ptr_n%0d", n), 64'(cp), 64'(m_ptr[d]));
    if (m_val[d]) begin
      chk($sformatf("seq_n%0d", n), 64'(cs), 64'(m_msg[d].seq_num));
      chk($sformatf("waddr_n%0d", n), 64'(ca), 64'(m_msg[d].waddr));
      chk($sformatf("preg_n%0d", n), 64'(cpr), 64'(m_msg[d].preg));
      chk($sformatf("wdata_n%0d", n), 64'(cd), 64'(m_msg[d].wdata));
    end
  endtask

  task automatic advance();
    int w;
    @(posedge clk);
    last_rst = rst;
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        m_ptr[d] = 0; m_val[d] = 1'b0; m_msg[d] = '0; last_w[d] = -1;
      end
    end else begin
      w = model_win(2, m_ptr[0], {1'b0, val2});
      last_w[0] = w;
      m_val[0] = (w >= 0);
      m_msg[0] = (w >= 0) ? msg2[w] : '0;
      if (w >= 0) m_ptr[0] = (w + 1) % 2;
      w = model_win(3, m_ptr[1], val3);
      last_w[1] = w;
      m_val[1] = (w >= 0);
      m_msg[1] = (w >= 0) ? msg3[w] : '0;
      if (w >= 0) m_ptr[1] = (w + 1) % 3;
    end
    #1;
  endtask

  task automatic cycle();
    @(negedge clk);
    check_dut(0, 2, {1'b0, val2}, {1'b0, rdy2}, o2_val, o2_wen, {1'b0, o2_ptr},
              o2_seq, o2_waddr, o2_preg, o2_wdata);
    check_dut(1, 3, val3, rdy3, o3_val, o3_wen, o3_ptr, o3_seq, o3_waddr, o3_preg, o3_wdata);
    advance();
  endtask

  initial begin
    int order [4] = '{2, 0, 1, 2};
    logic [63:0] r64;

    // Reset held two cycles with both N=2 pipes requesting.
    rst = 1'b1; val2 = 2'b11; val3 = 3'b000; msg2 = '0; msg3 = '0;
    msg2[0].preg = 6'd33; msg2[0].seq_num = 5'd1; msg2[0].wen = 1'b1;
    msg2[1].preg = 6'd34; msg2[1].seq_num = 5'd2; msg2[1].wen = 1'b1;
    advance();
    #1 chk("t1_rdy_in_reset", 64'(rdy2), 64'd0);
    cycle();
    chk("t1_val_in_reset", 64'(o2_val), 64'd0);
    chk("t1_ptr_in_reset", 64'(o2_ptr), 64'd0);

    // Release into contention: grants alternate 0,1,... with pregs 33/34 a cycle later.
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1 chk("t2_rdy_alt", 64'(rdy2), (i % 2 == 0) ? 64'd1 : 64'd2);
      cycle();
      chk("t2_val", 64'(o2_val), 64'd1);
      chk("t2_preg_alt", 64'(o2_preg), (i % 2 == 0) ? 64'd33 : 64'd34);
    end

    // Single requester while the pointer favours pipe1.
    val2 = 2'b01;
    cycle();
    chk("t3_ptr_setup", 64'(o2_ptr), 64'd1);
    msg2[0].seq_num = 5'd7; msg2[0].waddr = 5'd3; msg2[0].preg = 6'd10;
    msg2[0].wdata = 32'hDEAD_BEEF; msg2[0].wen = 1'b1;
    #1 chk("t3_rdy_single", 64'(rdy2), 64'd1);
    cycle();
    chk("t3_seq", 64'(o2_seq), 64'd7);
    chk("t3_wdata", 64'(o2_wdata), 64'hDEAD_BEEF);
    chk("t3_ptr", 64'(o2_ptr), 64'd1);

    // Idle cycles keep the pointer and report no completion.
    val2 = 2'b00;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t4_val_idle", 64'(o2_val), 64'd0);
      chk("t4_wen_idle", 64'(o2_wen), 64'd0);
      chk("t4_ptr_hold", 64'(o2_ptr), 64'd1);
    end

    // N=3 wrap from pointer 2.
    val3 = 3'b010;
    for (int p = 0; p < 3; p++) msg3[p].preg = 6'(20 + p);
    cycle();
    chk("t5_ptr_setup", 64'(o3_ptr), 64'd2);
    val3 = 3'b111;
    for (int i = 0; i < 4; i++) begin
      #1 chk("t5_rdy_order", 64'(rdy3), 64'(1 << order[i]));
      cycle();
      chk("t5_ptr_range", 64'(o3_ptr < 2'd3), 64'd1);
      chk("t5_preg", 64'(o3_preg), 64'(20 + order[i]));
    end

    // Reset in the cycle after a grant drops the broadcast.
    val2 = 2'b11;
    cycle();
    rst = 1'b1;
    cycle();
    chk("t6_val_after_rst", 64'(o2_val), 64'd0);
    chk("t6_ptr_after_rst", 64'(o2_ptr), 64'd0);
    chk("t6_ptr3_after_rst", 64'(o3_ptr), 64'd0);
    rst = 1'b0; val2 = 2'b01; val3 = 3'b000;
    msg2[0].seq_num = 5'd4; msg2[0].wen = 1'b0;
    cycle();
    chk("t6_val_nowen", 64'(o2_val), 64'd1);
    chk("t6_wen_nowen", 64'(o2_wen), 64'd0);
    chk("t6_seq_nowen", 64'(o2_seq), 64'd4);

    // Randomized traffic; a waiting pipe holds its message until accepted.
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < 2; i++) begin
        if (last_rst || !val2[i] || last_w[0] == i) begin
          val2[i] = 1'($urandom_range(0, 1));
          r64 = {$urandom(), $urandom()};
          msg2[i] = r64[MSG_BITS-1:0];
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (last_rst || !val3[i] || last_w[1] == i) begin
          val3[i] = 1'($urandom_range(0, 1));
          r64 = {$urandom(), $urandom()};
          msg3[i] = r64[MSG_BITS-1:0];
        end
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
